// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory bus bridge.
package mem_bus_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] ERR_RDATA = '0;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
endpackage

// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if: core-side and bus-side signals of the bridge.
// master is the bridge's view; slave is the core/memory environment's view.
interface mem_bus_bridge_if;
  import mem_bus_pkg::*;
  logic              core_req;
  logic              core_we;
  logic [WORD_W-1:0] core_addr;
  logic [WORD_W-1:0] core_wdata;
  logic [WORD_W-1:0] core_rdata;
  logic              core_stall;
  logic              core_err;
  logic              bus_req;
  logic              bus_we;
  logic [WORD_W-1:0] bus_addr;
  logic [WORD_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [WORD_W-1:0] bus_rdata;
  modport master (
    input  core_req, core_we, core_addr, core_wdata, bus_ack, bus_rdata,
    output core_rdata, core_stall, core_err, bus_req, bus_we, bus_addr, bus_wdata
  );
  modport slave (
    output core_req, core_we, core_addr, core_wdata, bus_ack, bus_rdata,
    input  core_rdata, core_stall, core_err, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_bus_bridge_wait_counter.sv
// wait_counter: counts REQ cycles without ack; tc flags the last allowed cycle.
module wait_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign tc = cnt_q == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: stalls the core while a single word access runs on the external bus.
// Define MEM_TIMEOUT_EN to abort bus cycles that wait TIMEOUT_CYCLES without ack.
module mem_bus_bridge
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              reset,
  mem_bus_bridge_if.master m
);
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..255");
  end
  state_e            state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic              we_q, we_d, err_q, err_d;
  logic              timeout;
`ifdef MEM_TIMEOUT_EN
  wait_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != REQ),
    .en    (state_q == REQ && !m.bus_ack),
    .tc    (timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (m.core_req) begin
        if (m.core_addr[1:0] == 2'b00) begin
          addr_d  = m.core_addr;
          wdata_d = m.core_wdata;
          we_d    = m.core_we;
          err_d   = 1'b0;
          state_d = REQ;
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      // ack beats a simultaneous timeout
      REQ: if (m.bus_ack) begin
        rdata_d = we_q ? ERR_RDATA : m.bus_rdata;
        err_d   = 1'b0;
        state_d = DONE;
      end else if (timeout) begin
        rdata_d = ERR_RDATA;
        err_d   = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  assign m.bus_req    = state_q == REQ;
  assign m.bus_we     = we_q;
  assign m.bus_addr   = addr_q;
  assign m.bus_wdata  = wdata_q;
  assign m.core_rdata = rdata_q;
  assign m.core_stall = m.core_req && state_q != DONE;
  assign m.core_err   = state_q == DONE && err_q;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed cycle-by-cycle checks of the bridge handshake.
module tb_mem_bus_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  mem_bus_bridge_if b ();
  mem_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .reset(reset), .m(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    b.core_req = 0; b.core_we = 0; b.core_addr = 0; b.core_wdata = 0;
    b.bus_ack = 0; b.bus_rdata = 0;
    @(negedge clk); #1;
    chk("rst_bus_req", 32'(b.bus_req), 0);
    chk("rst_bus_we", 32'(b.bus_we), 0);
    chk("rst_bus_addr", b.bus_addr, 0);
    chk("rst_bus_wdata", b.bus_wdata, 0);
    chk("rst_rdata", b.core_rdata, 0);
    chk("rst_err", 32'(b.core_err), 0);
    @(negedge clk); reset = 0;
    // load 0x100, ack in second REQ cycle
    @(negedge clk); b.core_req = 1; b.core_we = 0; b.core_addr = 32'h100; #1;
    chk("ld_c1_stall", 32'(b.core_stall), 1);
    chk("ld_c1_bus_req", 32'(b.bus_req), 0);
    @(negedge clk); #1;
    chk("ld_c2_bus_req", 32'(b.bus_req), 1);
    chk("ld_c2_addr", b.bus_addr, 32'h100);
    chk("ld_c2_we", 32'(b.bus_we), 0);
    chk("ld_c2_stall", 32'(b.core_stall), 1);
    @(negedge clk); b.bus_ack = 1; b.bus_rdata = 32'hCAFEF00D; #1;
    chk("ld_c3_bus_req", 32'(b.bus_req), 1);
    chk("ld_c3_stall", 32'(b.core_stall), 1);
    @(negedge clk); b.bus_ack = 0; #1;
    chk("ld_rel_stall", 32'(b.core_stall), 0);
    chk("ld_rel_err", 32'(b.core_err), 0);
    chk("ld_rel_rdata", b.core_rdata, 32'hCAFEF00D);
    chk("ld_rel_bus_req", 32'(b.bus_req), 0);
    b.core_req = 0;
    @(negedge clk); #1;
    chk("ld_hold_rdata", b.core_rdata, 32'hCAFEF00D);
    // store 0x204, immediate ack; store captures zero
    @(negedge clk); b.core_req = 1; b.core_we = 1; b.core_addr = 32'h204; b.core_wdata = 32'h12345678; #1;
    chk("st_c1_stall", 32'(b.core_stall), 1);
    @(negedge clk); b.bus_ack = 1; b.bus_rdata = 32'hDEADBEEF; #1;
    chk("st_bus_req", 32'(b.bus_req), 1);
    chk("st_bus_we", 32'(b.bus_we), 1);
    chk("st_bus_addr", b.bus_addr, 32'h204);
    chk("st_bus_wdata", b.bus_wdata, 32'h12345678);
    @(negedge clk); b.bus_ack = 0; #1;
    chk("st_rel_stall", 32'(b.core_stall), 0);
    chk("st_rel_err", 32'(b.core_err), 0);
    chk("st_rel_rdata", b.core_rdata, 0);
    b.core_req = 0; b.core_we = 0;
    // misaligned load 0x102
    @(negedge clk); b.core_req = 1; b.core_addr = 32'h102; #1;
    chk("mis_c1_bus_req", 32'(b.bus_req), 0);
    chk("mis_c1_stall", 32'(b.core_stall), 1);
    @(negedge clk); #1;
    chk("mis_rel_bus_req", 32'(b.bus_req), 0);
    chk("mis_rel_err", 32'(b.core_err), 1);
    chk("mis_rel_stall", 32'(b.core_stall), 0);
    b.core_req = 0;
    @(negedge clk); #1;
    chk("mis_idle_err", 32'(b.core_err), 0);
    // ack while idle is ignored
    b.bus_ack = 1; b.bus_rdata = 32'h55;
    @(negedge clk); b.bus_ack = 0; #1;
    chk("idle_ack_rdata", b.core_rdata, 0);
    chk("idle_ack_bus_req", 32'(b.bus_req), 0);
    // core_req dropped mid-transaction does not abort
    @(negedge clk); b.core_req = 1; b.core_addr = 32'h300; #1;
    @(negedge clk); b.core_req = 0; #1;
    chk("drop_bus_req", 32'(b.bus_req), 1);
    chk("drop_stall", 32'(b.core_stall), 0);
    @(negedge clk); b.bus_ack = 1; b.bus_rdata = 32'hA5A50001; #1;
    chk("drop_bus_req2", 32'(b.bus_req), 1);
    // new request held during DONE is only accepted after IDLE
    @(negedge clk); b.bus_ack = 0; b.core_req = 1; b.core_addr = 32'h400; #1;
    chk("drop_rel_rdata", b.core_rdata, 32'hA5A50001);
    chk("drop_rel_err", 32'(b.core_err), 0);
    chk("done_stall", 32'(b.core_stall), 0);
    @(negedge clk); #1;
    chk("done_next_idle_bus_req", 32'(b.bus_req), 0);
    chk("done_next_idle_stall", 32'(b.core_stall), 1);
    @(negedge clk); #1;
    chk("acc_bus_req", 32'(b.bus_req), 1);
    chk("acc_bus_addr", b.bus_addr, 32'h400);
    // reset in second REQ cycle
    @(negedge clk); #1;
    chk("rstmid_bus_req_pre", 32'(b.bus_req), 1);
    reset = 1; #1;
    chk("rstmid_bus_req", 32'(b.bus_req), 0);
    chk("rstmid_bus_addr", b.bus_addr, 0);
    chk("rstmid_rdata", b.core_rdata, 0);
    b.bus_ack = 1; b.bus_rdata = 32'h99;
    @(negedge clk); reset = 0; b.core_req = 0; #1;
    @(negedge clk); b.bus_ack = 0; #1;
    chk("late_ack_bus_req", 32'(b.bus_req), 0);
    chk("late_ack_rdata", b.core_rdata, 0);
    chk("late_ack_err", 32'(b.core_err), 0);
`ifdef MEM_TIMEOUT_EN
    @(negedge clk); b.core_req = 1; b.core_addr = 32'h600; #1;
    @(negedge clk); b.bus_ack = 1; b.bus_rdata = 32'h77; #1;
    @(negedge clk); b.bus_ack = 0; b.core_req = 0; #1;
    chk("to_pre_rdata", b.core_rdata, 32'h77);
    @(negedge clk); b.core_req = 1; b.core_addr = 32'h700; #1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("to_bus_req_c%0d", i), 32'(b.bus_req), 1);
    end
    @(negedge clk); b.core_req = 0; #1;
    chk("to_bus_req_low", 32'(b.bus_req), 0);
    chk("to_err", 32'(b.core_err), 1);
    chk("to_rdata", b.core_rdata, 0);
    chk("to_stall", 32'(b.core_stall), 0);
    @(negedge clk); b.core_req = 1; b.core_addr = 32'h704; #1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("tw_bus_req_c%0d", i), 32'(b.bus_req), 1);
    end
    @(negedge clk); b.bus_ack = 1; b.bus_rdata = 32'hBEEF; #1;
    chk("tw_bus_req_c4", 32'(b.bus_req), 1);
    @(negedge clk); b.bus_ack = 0; b.core_req = 0; #1;
    chk("tw_err", 32'(b.core_err), 0);
    chk("tw_rdata", b.core_rdata, 32'hBEEF);
`else
    @(negedge clk); b.core_req = 1; b.core_addr = 32'h800; #1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); #1;
      chk($sformatf("wait_bus_req_c%0d", i), 32'(b.bus_req), 1);
    end
    @(negedge clk); b.bus_ack = 1; b.bus_rdata = 32'h0BADF00D; #1;
    @(negedge clk); b.bus_ack = 0; b.core_req = 0; #1;
    chk("wait_err", 32'(b.core_err), 0);
    chk("wait_rdata", b.core_rdata, 32'h0BADF00D);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
